// File: rtl/conv_output_writer.sv
// conv_output_writer: collects one OUT_SIZE x OUT_SIZE frame of convolver results and
// writes them in raster order to an output buffer through a registered write port.
// Optional ReLU on the write data when CONV_OUTPUT_WRITER_RELU_EN is defined
// (default build: data passed through unchanged).
module conv_output_writer #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned IMAGE_SIZE  = 28,
  parameter int unsigned KERNEL_SIZE = 5,
  parameter int unsigned ADDR_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam int unsigned OUT_SIZE = IMAGE_SIZE - KERNEL_SIZE + 1;
  localparam int unsigned CntW     = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(OUT_SIZE - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       col_q, col_d;
  logic [CntW-1:0]       row_q, row_d;
  logic [ADDR_WIDTH-1:0] pix_q, pix_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0] data_out;

`ifdef CONV_OUTPUT_WRITER_RELU_EN
  // ReLU: clamp negative results to zero before they are registered.
  always_comb begin
    data_out = in_data[DATA_WIDTH-1] ? '0 : in_data;
  end
`else
  assign data_out = in_data;
`endif

  // Next-state for the FSM, raster counters and the registered write port.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    pix_d        = pix_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          // A valid coincident with start is dropped silently.
          state_d   = StCollect;
          busy_d    = 1'b1;
          overrun_d = 1'b0;
          col_d     = '0;
          row_d     = '0;
          pix_d     = '0;
        end else if (in_valid) begin
          overrun_d = 1'b1;
        end
      end
      StCollect: begin
        if (in_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = pix_q;
          wr_data_d = data_out;
          pix_d     = pix_q + 1'b1;
          if (col_q == LastIdx) begin
            col_d = '0;
            if (row_q == LastIdx) begin
              row_d        = '0;
              pix_d        = '0;
              state_d      = StDone;
              busy_d       = 1'b0;
              frame_done_d = 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        if (in_valid) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; asynchronous reset clears everything.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      pix_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      pix_q        <= pix_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule
